turn_scheduler: RTL and testbench

//  Sequences one tic-tac-toe episode between the learning agent (policy generator) and the player.

---
 rtl/turn_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_turn_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_scheduler.sv
// Episode sequencer for one tic-tac-toe game between the learning agent and
// the player: grants alternate turns, rejects illegal moves, owns the board,
// samples the external judge after every accepted move and reports outcomes.
module turn_scheduler #(
  parameter int MOVE_TIMEOUT = 100,  // agent turn length before forfeit (>=2)
  parameter int MAX_ILLEGAL  = 3,    // illegal agent moves per turn before forfeit (>=1)
  parameter int EP_W         = 16    // episode_count width
) (
  input  logic            clock,
  input  logic            enable,
  input  logic            first_player,
  input  logic            agent_valid,
  input  logic [3:0]      agent_action,
  output logic            agent_ready,
  input  logic            player_valid,
  input  logic [3:0]      player_action,
  output logic            player_ready,
  output logic [17:0]     board,
  input  logic [1:0]      judge_result,
  output logic [1:0]      outcome,
  output logic            outcome_valid,
  output logic            illegal,
  output logic            rst_policygen,
  output logic [EP_W-1:0] episode_count
);

  localparam int TIMER_W = $clog2(MOVE_TIMEOUT);
  localparam int ILL_W   = $clog2(MAX_ILLEGAL + 1);

  localparam logic [1:0] CELL_AGENT  = 2'b01;
  localparam logic [1:0] CELL_PLAYER = 2'b10;
  localparam logic [1:0] RES_CONT    = 2'b00;
  localparam logic [1:0] RES_FORFEIT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_TURN_A,
    S_TURN_P,
    S_JUDGE,
    S_END
  } state_t;

  state_t state, state_next;

  logic [TIMER_W-1:0] timer;
  logic [ILL_W-1:0]   illegal_cnt;
  logic               last_mover;   // 1 = the player made the move under judgement

  // Move decode shared by both turns.
  logic [15:0] occupied;
  logic [3:0]  move_action;
  logic        move_hs;
  logic        move_legal;
  logic [1:0]  mover_code;

  // Combinational decision flags consumed by the datapath register.
  logic        go_end;
  logic [1:0]  end_code;

  // Turn-open and pulse outputs decode straight from the state.
  assign agent_ready   = (state == S_TURN_A);
  assign player_ready  = (state == S_TURN_P);
  assign rst_policygen = (state == S_START);
  assign outcome_valid = (state == S_END);

  // Occupancy map; codes 9..15 read as permanently occupied so one lookup covers both illegal cases.
  always_comb begin
    occupied = '1;
    for (int k = 0; k < 9; k++) begin
      occupied[k] = |board[2*k +: 2];
    end
  end

  // Select the side that owns the turn; the other side's valid is ignored.
  always_comb begin
    move_action = player_ready ? player_action : agent_action;
    move_hs     = (agent_ready & agent_valid) | (player_ready & player_valid);
    move_legal  = move_hs & ~occupied[move_action];
    mover_code  = player_ready ? CELL_PLAYER : CELL_AGENT;
  end

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (!enable) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and end-of-episode decision.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    state_next = state;
    go_end     = 1'b0;
    end_code   = RES_FORFEIT;
    unique case (state)
      S_IDLE:  state_next = S_START;
      S_START: state_next = first_player ? S_TURN_P : S_TURN_A;
      S_TURN_A: begin
        if (move_hs) begin
          if (move_legal) begin
            state_next = S_JUDGE;
          end else if (illegal_cnt == ILL_W'(MAX_ILLEGAL - 1)) begin
            go_end   = 1'b1;
            end_code = RES_FORFEIT;
          end
        end else if (timer == TIMER_W'(MOVE_TIMEOUT - 1)) begin
          go_end   = 1'b1;
          end_code = RES_FORFEIT;
        end
      end
      S_TURN_P: begin
        if (move_legal) begin
          state_next = S_JUDGE;
        end
      end
      S_JUDGE: begin
        if (judge_result == RES_CONT) begin
          state_next = last_mover ? S_TURN_A : S_TURN_P;
        end else begin
          go_end   = 1'b1;
          end_code = judge_result;
        end
      end
      S_END:   state_next = S_START;
      default: state_next = S_IDLE;
    endcase
    if (go_end) begin
      state_next = S_END;
    end
  end

  // Board, per-turn counters, outcome and episode statistics.
  always_ff @(posedge clock) begin
    // NOTE: the board is an ordinary 18-bit register, not a memory, and must
    // read as empty straight after reset, so it takes the reset like the rest.
    if (!enable) begin
      board         <= '0;
      timer         <= '0;
      illegal_cnt   <= '0;
      last_mover    <= 1'b0;
      outcome       <= '0;
      episode_count <= '0;
      illegal       <= 1'b0;
    end else begin
      illegal <= move_hs & ~move_legal;

      unique case (state)
        S_START: begin
          board       <= '0;
          timer       <= '0;
          illegal_cnt <= '0;
        end
        S_TURN_A, S_TURN_P: begin
          if (move_legal) begin
            for (int k = 0; k < 9; k++) begin
              if (move_action == 4'(k)) begin
                board[2*k +: 2] <= mover_code;
              end
            end
            last_mover <= player_ready;
          end
          if (agent_ready) begin
            if (move_hs && !move_legal) begin
              illegal_cnt <= illegal_cnt + 1'b1;
            end else if (!move_hs) begin
              timer <= timer + 1'b1;
            end
          end
        end
        S_JUDGE: begin
          timer       <= '0;
          illegal_cnt <= '0;
        end
        default: ;
      endcase

      if (go_end) begin
        outcome <= end_code;
        if (episode_count != '1) begin
          episode_count <= episode_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// Self-checking bench for turn_scheduler: directed episodes (win, forfeit,
// timeout, mid-episode reset, draw) followed by randomized games, checked
// against a board-array model of the rules and a real tic-tac-toe judge.
module tb_turn_scheduler;

  logic        clock = 1'b0;
  logic        enable = 1'b0;
  logic        first_player = 1'b0;
  logic        agent_valid = 1'b0;
  logic [3:0]  agent_action = '0;
  logic        agent_ready;
  logic        player_valid = 1'b0;
  logic [3:0]  player_action = '0;
  logic        player_ready;
  logic [17:0] board;
  logic [1:0]  judge_result;
  logic [1:0]  outcome;
  logic        outcome_valid;
  logic        illegal;
  logic        rst_policygen;
  logic [15:0] episode_count;

  int checks = 0;
  int failures = 0;

  // Reference model of the game.
  int cells[9];
  int turn;          // 0 = agent to move, 1 = player to move
  bit ended;
  int ill_cnt;
  int exp_count = 0;

  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  turn_scheduler #(.MOVE_TIMEOUT(100), .MAX_ILLEGAL(3), .EP_W(16)) dut (
    .clock(clock), .enable(enable), .first_player(first_player),
    .agent_valid(agent_valid), .agent_action(agent_action), .agent_ready(agent_ready),
    .player_valid(player_valid), .player_action(player_action), .player_ready(player_ready),
    .board(board), .judge_result(judge_result), .outcome(outcome),
    .outcome_valid(outcome_valid), .illegal(illegal), .rst_policygen(rst_policygen),
    .episode_count(episode_count)
  );

  always #5 clock = ~clock;

  // Tic-tac-toe judge on a packed board.
  function automatic logic [1:0] judge(input logic [17:0] b);
    logic [1:0] c0, c1, c2;
    bit full;
    for (int l = 0; l < 8; l++) begin
      c0 = b[2*lines[l][0] +: 2];
      c1 = b[2*lines[l][1] +: 2];
      c2 = b[2*lines[l][2] +: 2];
      if (c0 != 2'b00 && c0 == c1 && c1 == c2) return c0;
    end
    full = 1'b1;
    for (int k = 0; k < 9; k++) if (b[2*k +: 2] == 2'b00) full = 1'b0;
    return full ? 2'b11 : 2'b00;
  endfunction

  always_comb judge_result = judge(board);

  function automatic logic [17:0] pack_cells();
    logic [17:0] v = '0;
    for (int k = 0; k < 9; k++) v[2*k +: 2] = 2'(cells[k]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called while sampling the END cycle; leaves the bench sampling START.
  task automatic finish_episode(input logic [1:0] v);
    check("end_valid", outcome_valid, 1);
    check("end_outcome", outcome, v);
    if (exp_count != 65535) exp_count++;
    check("episode_count", episode_count, exp_count);
    ended = 1'b1;
    step();
    check("start_pulse", rst_policygen, 1);
    check("valid_drop", outcome_valid, 0);
    check("outcome_hold", outcome, v);
    check("board_held", board, pack_cells());
  endtask

  // Called while sampling START; leaves the bench sampling the first turn.
  task automatic start_episode(input bit fp);
    first_player = fp;
    step();
    for (int k = 0; k < 9; k++) cells[k] = 0;
    turn = fp;
    ended = 1'b0;
    ill_cnt = 0;
    check("board_clear", board, 0);
    check("pulse_single", rst_policygen, 0);
    check("first_agent", agent_ready, (fp == 1'b0));
    check("first_player", player_ready, (fp == 1'b1));
  endtask

  // One move by the side holding the turn, with idle cycles and noise from the other side.
  task automatic move(input bit is_agent, input int a, input int idle);
    bit legal;
    logic [1:0] v;
    for (int i = 0; i < idle; i++) begin
      if (is_agent) begin
        player_valid = 1'b1; player_action = 4'($urandom_range(0, 15));
      end else begin
        agent_valid = 1'b1; agent_action = 4'($urandom_range(0, 15));
      end
      step();
      check("idle_board", board, pack_cells());
      check("idle_illegal", illegal, 0);
      check("idle_ready", is_agent ? agent_ready : player_ready, 1);
    end
    if (is_agent) begin
      agent_valid = 1'b1; agent_action = 4'(a);
      player_valid = 1'($urandom_range(0, 1)); player_action = 4'($urandom_range(0, 15));
    end else begin
      player_valid = 1'b1; player_action = 4'(a);
      agent_valid = 1'($urandom_range(0, 1)); agent_action = 4'($urandom_range(0, 15));
    end
    step();
    agent_valid = 1'b0;
    player_valid = 1'b0;
    legal = (a <= 8) ? (cells[a] == 0) : 1'b0;
    if (legal) begin
      cells[a] = is_agent ? 1 : 2;
      ill_cnt = 0;
      check("move_board", board, pack_cells());
      check("move_no_illegal", illegal, 0);
      check("judge_ready", {agent_ready, player_ready}, 0);
      v = judge(pack_cells());
      step();
      if (v == 2'b00) begin
        turn = is_agent ? 1 : 0;
        check("next_agent", agent_ready, (turn == 0));
        check("next_player", player_ready, (turn == 1));
      end else begin
        finish_episode(v);
      end
    end else begin
      check("illegal_pulse", illegal, 1);
      check("illegal_board", board, pack_cells());
      if (is_agent) begin
        ill_cnt++;
        if (ill_cnt == 3) finish_episode(2'b10);
        else check("stay_agent", agent_ready, 1);
      end else begin
        check("stay_player", player_ready, 1);
      end
    end
  endtask

  initial begin
    int n;
    int guard;
    int a;
    int empties[$];
    int draw_seq[9] = '{0, 4, 8, 1, 7, 6, 2, 5, 3};

    // Reset state.
    enable = 1'b0;
    step();
    step();
    check("rst_board", board, 0);
    check("rst_outcome", outcome, 0);
    check("rst_count", episode_count, 0);
    check("rst_flags", {agent_ready, player_ready, outcome_valid, illegal, rst_policygen}, 0);
    enable = 1'b1;
    step();
    check("first_start", rst_policygen, 1);

    // Agent wins on the top row; outcome two cycles after the winning move.
    start_episode(1'b0);
    move(1'b1, 0, 0);
    move(1'b0, 3, 1);
    move(1'b1, 1, 2);
    move(1'b0, 4, 0);
    move(1'b1, 2, 0);
    check("win_ended", ended, 1);

    // Ignored player valid during the agent turn, then three illegal agent moves.
    start_episode(1'b1);
    move(1'b0, 4, 0);
    player_valid = 1'b1;
    player_action = 4'd5;
    step();
    player_valid = 1'b0;
    check("ignored_board", board, pack_cells());
    check("ignored_illegal", illegal, 0);
    check("ignored_ready", agent_ready, 1);
    move(1'b1, 4, 0);
    move(1'b1, 9, 1);
    move(1'b1, 4, 0);
    check("forfeit_ended", ended, 1);

    // Agent idles until the turn timer expires.
    start_episode(1'b0);
    n = 0;
    while (agent_ready === 1'b1 && n < 150) begin
      n++;
      step();
    end
    check("timeout_cycles", n, 100);
    finish_episode(2'b10);

    // Reset in the middle of a player turn with cell 4 filled.
    start_episode(1'b1);
    move(1'b0, 4, 0);
    move(1'b1, 0, 0);
    check("mid_turn_p", player_ready, 1);
    enable = 1'b0;
    step();
    exp_count = 0;
    check("mid_rst_board", board, 0);
    check("mid_rst_outcome", outcome, 0);
    check("mid_rst_count", episode_count, 0);
    check("mid_rst_flags", {agent_ready, player_ready, outcome_valid, illegal, rst_policygen}, 0);
    enable = 1'b1;
    step();
    check("mid_rst_start", rst_policygen, 1);

    // Nine legal moves ending in a draw.
    start_episode(1'b0);
    for (int i = 0; i < 9; i++) move(i % 2 == 0, draw_seq[i], 0);
    check("draw_ended", ended, 1);
    start_episode(1'b0);

    // Randomized episodes.
    for (int ep = 0; ep < 30; ep++) begin
      if (ep > 0) start_episode(1'($urandom_range(0, 1)));
      guard = 0;
      while (!ended && guard < 80) begin
        guard++;
        empties.delete();
        for (int k = 0; k < 9; k++) if (cells[k] == 0) empties.push_back(k);
        if ($urandom_range(0, 4) == 0 || empties.size() == 0) a = int'($urandom_range(0, 15));
        else a = empties[$urandom_range(0, empties.size() - 1)];
        move(turn == 0, a, int'($urandom_range(0, 2)));
      end
      if (!ended) begin
        failures++;
        $display("FAIL random_episode_bound observed=%0d moves expected=episode end", guard);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "episode did not end");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
